// File: rtl/song_sequencer.sv
// Song sequencer: walks a song's ROM entries and hands each note and
// its duration to the note player, pulsing song_done at the end.
module song_sequencer #(
   parameter int IDX_W  = 5,
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    play,
   input  logic                    reset_player,
   input  logic [1:0]              song,
   input  logic                    note_done,
   input  logic [NOTE_W+DUR_W-1:0] rom_data,
   output logic [IDX_W+1:0]        rom_addr,
   output logic [NOTE_W-1:0]       note_out,
   output logic [DUR_W-1:0]        duration_out,
   output logic                    new_note,
   output logic                    song_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_ISSUE,
      S_PLAYING,
      S_DONE
   } state_t;

   localparam logic [IDX_W-1:0] IDX_LAST = '1;
   localparam logic [IDX_W-1:0] IDX_ONE  = 1;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [1:0]       song_q;
   logic [IDX_W-1:0] idx_inc;
   logic             dur_zero;

   assign idx_inc  = idx + IDX_ONE;
   assign dur_zero = (rom_data[DUR_W-1:0] == '0);

   // Strobes decode the state register; play gates the issue strobe so
   // a paused note is announced in the first cycle play returns.
   assign new_note  = (state == S_ISSUE) && play && !reset_player;
   assign song_done = (state == S_DONE) && !reset_player;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         idx          <= '0;
         song_q       <= '0;
         rom_addr     <= '0;
         note_out     <= '0;
         duration_out <= '0;
      end else if (reset_player) begin
         state <= S_IDLE;
         idx   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (play) begin
                  song_q   <= song;
                  idx      <= '0;
                  rom_addr <= {song, {IDX_W{1'b0}}};
                  state    <= S_FETCH;
               end
            end
            S_FETCH: begin
               rom_addr <= {song_q, idx};
               if (play) state <= S_WAIT;
            end
            S_WAIT: begin
               if (dur_zero) begin
                  state <= S_DONE;
               end else begin
                  note_out     <= rom_data[NOTE_W+DUR_W-1:DUR_W];
                  duration_out <= rom_data[DUR_W-1:0];
                  state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (play) state <= S_PLAYING;
            end
            S_PLAYING: begin
               if (note_done) begin
                  if (idx == IDX_LAST) begin
                     state <= S_DONE;
                  end else begin
                     // Address leads by one cycle so ROM data lands in WAIT
                     idx      <= idx_inc;
                     rom_addr <= {song_q, idx_inc};
                     state    <= S_FETCH;
                  end
               end
            end
            S_DONE: begin
               idx   <= '0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: per-cycle vector table plus
// hand-written sequences for full songs, pausing and resets.
module tb_song_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        play;
   logic        reset_player;
   logic [1:0]  song;
   logic        note_done;
   logic [11:0] rom_data = '0;
   logic [6:0]  rom_addr;
   logic [5:0]  note_out;
   logic [5:0]  duration_out;
   logic        new_note;
   logic        song_done;

   int errors = 0;
   int checks = 0;

   logic [11:0] rom [128];

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   song_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .play         (play),
      .reset_player (reset_player),
      .song         (song),
      .note_done    (note_done),
      .rom_data     (rom_data),
      .rom_addr     (rom_addr),
      .note_out     (note_out),
      .duration_out (duration_out),
      .new_note     (new_note),
      .song_done    (song_done)
   );

   typedef struct {
      logic       play;
      logic       rp;
      logic [1:0] song;
      logic       nd;
      logic [6:0] addr;
      logic [5:0] note;
      logic [5:0] dur;
      logic       nn;
      logic       sd;
   } vec_t;

   vec_t vt [17];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  name, act, act, exp, exp);
      end
   endtask

   task automatic run_song(input logic [1:0] s, input int exp_notes,
                           input string tag);
      int notes = 0;
      int dones = 0;
      int cd = 0;
      int tail = -1;
      logic both = 1'b0;
      logic addr_bad = 1'b0;
      logic [6:0] ea;
      play = 1'b1;
      song = s;
      for (int c = 0; c < 600 && tail != 0; c++) begin
         @(negedge clk);
         note_done = (cd == 1);
         if (cd > 0) cd--;
         #1;
         if (c >= 1 && rom_addr[6:5] != s) addr_bad = 1'b1;
         if (new_note && song_done) both = 1'b1;
         if (new_note) begin
            ea = {s, 5'(notes)};
            chk({tag, " addr"}, int'(rom_addr), int'(ea));
            chk({tag, " note"}, int'(note_out), int'(rom[ea][11:6]));
            chk({tag, " dur"}, int'(duration_out), int'(rom[ea][5:0]));
            notes++;
            cd = 2;
         end
         if (song_done) begin
            dones++;
            play = 1'b0;
            if (tail < 0) tail = 9;
         end
         if (tail > 0) tail--;
      end
      note_done = 1'b0;
      play = 1'b0;
      chk({tag, " note count"}, notes, exp_notes);
      chk({tag, " song_done count"}, dones, 1);
      chk({tag, " addr song bits"}, int'(addr_bad), 0);
      chk({tag, " nn and sd together"}, int'(both), 0);
   endtask

   initial begin
      logic bad;
      for (int a = 0; a < 128; a++) begin
         rom[a][11:6] = 6'(a + 1);
         rom[a][5:0]  = 6'((a % 7) + 1);
      end
      rom[7'h20] = {6'd10, 6'd4};
      rom[7'h43] = {6'd9, 6'd0};

      //            play rp song nd  addr   note dur nn sd
      vt[0]  = '{1'b1, 1'b0, 2'd1, 1'b0, 7'h00, 6'd0,  6'd0, 1'b0, 1'b0};
      vt[1]  = '{1'b1, 1'b0, 2'd1, 1'b0, 7'h20, 6'd0,  6'd0, 1'b0, 1'b0};
      vt[2]  = '{1'b1, 1'b0, 2'd1, 1'b0, 7'h20, 6'd0,  6'd0, 1'b0, 1'b0};
      vt[3]  = '{1'b1, 1'b0, 2'd1, 1'b0, 7'h20, 6'd10, 6'd4, 1'b1, 1'b0};
      vt[4]  = '{1'b1, 1'b0, 2'd1, 1'b0, 7'h20, 6'd10, 6'd4, 1'b0, 1'b0};
      vt[5]  = '{1'b1, 1'b0, 2'd1, 1'b1, 7'h20, 6'd10, 6'd4, 1'b0, 1'b0};
      vt[6]  = '{1'b1, 1'b0, 2'd1, 1'b0, 7'h21, 6'd10, 6'd4, 1'b0, 1'b0};
      vt[7]  = '{1'b1, 1'b0, 2'd1, 1'b0, 7'h21, 6'd10, 6'd4, 1'b0, 1'b0};
      vt[8]  = '{1'b1, 1'b0, 2'd1, 1'b0, 7'h21, 6'd34, 6'd6, 1'b1, 1'b0};
      vt[9]  = '{1'b1, 1'b1, 2'd1, 1'b1, 7'h21, 6'd34, 6'd6, 1'b0, 1'b0};
      vt[10] = '{1'b0, 1'b0, 2'd1, 1'b0, 7'h21, 6'd34, 6'd6, 1'b0, 1'b0};
      vt[11] = '{1'b1, 1'b0, 2'd3, 1'b0, 7'h21, 6'd34, 6'd6, 1'b0, 1'b0};
      vt[12] = '{1'b1, 1'b0, 2'd3, 1'b0, 7'h60, 6'd34, 6'd6, 1'b0, 1'b0};
      vt[13] = '{1'b1, 1'b0, 2'd3, 1'b0, 7'h60, 6'd34, 6'd6, 1'b0, 1'b0};
      vt[14] = '{1'b1, 1'b0, 2'd3, 1'b0, 7'h60, 6'd33, 6'd6, 1'b1, 1'b0};
      vt[15] = '{1'b0, 1'b1, 2'd3, 1'b0, 7'h60, 6'd33, 6'd6, 1'b0, 1'b0};
      vt[16] = '{1'b0, 1'b0, 2'd3, 1'b0, 7'h60, 6'd33, 6'd6, 1'b0, 1'b0};

      reset = 1'b1;
      play = 1'b0;
      reset_player = 1'b0;
      song = 2'd0;
      note_done = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset addr", int'(rom_addr), 0);
      chk("reset nn", int'(new_note), 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         play = vt[i].play;
         reset_player = vt[i].rp;
         song = vt[i].song;
         note_done = vt[i].nd;
         #1;
         chk($sformatf("vec%0d addr", i), int'(rom_addr), int'(vt[i].addr));
         chk($sformatf("vec%0d note", i), int'(note_out), int'(vt[i].note));
         chk($sformatf("vec%0d dur", i), int'(duration_out), int'(vt[i].dur));
         chk($sformatf("vec%0d nn", i), int'(new_note), int'(vt[i].nn));
         chk($sformatf("vec%0d sd", i), int'(song_done), int'(vt[i].sd));
      end
      reset_player = 1'b0;
      note_done = 1'b0;
      play = 1'b0;

      run_song(2'd2, 3, "song2");
      run_song(2'd0, 32, "song0");

      // Pause in ISSUE, with a song change that must be ignored
      @(negedge clk);
      play = 1'b1;
      song = 2'd1;
      repeat (2) @(negedge clk);
      @(negedge clk);
      play = 1'b0;
      song = 2'd3;
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         if (new_note) bad = 1'b1;
      end
      chk("pause nn low", int'(bad), 0);
      @(negedge clk);
      play = 1'b1;
      #1;
      chk("resume nn", int'(new_note), 1);
      chk("resume note", int'(note_out), 10);

      // note_done while paused still advances, then parks in FETCH
      @(negedge clk);
      play = 1'b0;
      note_done = 1'b1;
      @(negedge clk);
      note_done = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         if (new_note) bad = 1'b1;
      end
      chk("park addr", int'(rom_addr), 'h21);
      chk("park nn low", int'(bad), 0);
      @(negedge clk);
      play = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("after park nn", int'(new_note), 1);
      chk("after park note", int'(note_out), 34);
      chk("after park addr", int'(rom_addr), 'h21);

      // Async reset while PLAYING
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("async addr", int'(rom_addr), 0);
      chk("async note", int'(note_out), 0);
      chk("async dur", int'(duration_out), 0);
      chk("async nn", int'(new_note), 0);
      chk("async sd", int'(song_done), 0);
      @(negedge clk);
      play = 1'b0;
      reset = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         if (new_note || song_done || rom_addr != 7'h00) bad = 1'b1;
      end
      chk("post reset idle", int'(bad), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
